// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// TX_STATUS bit positions and the GPIO width.
package dmem_pkg;
  localparam logic [7:0] OFS_CYCLE_LO  = 8'h00;
  localparam logic [7:0] OFS_CYCLE_HI  = 8'h04;
  localparam logic [7:0] OFS_GPIO      = 8'h08;
  localparam logic [7:0] OFS_TX_DATA   = 8'h0C;
  localparam logic [7:0] OFS_TX_STATUS = 8'h10;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  localparam int GPIO_W = 16;
endpackage

// File: rtl/dmem_tx_fifo.sv
// Byte-wide circular TX FIFO. A push while full is accepted only when a
// pop happens on the same edge, so the count stays unchanged.
module dmem_tx_fifo #(
  parameter int TXF_DEPTH_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [TXF_DEPTH_LOG2:0] count,
  output logic [7:0]              head
);
  localparam int DEPTH = 1 << TXF_DEPTH_LOG2;
  localparam logic [TXF_DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [TXF_DEPTH_LOG2:0]   CNT_MAX = CNT_ONE << TXF_DEPTH_LOG2;
  localparam logic [TXF_DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [7:0]                mem_q [DEPTH];
  logic [TXF_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                      do_push, do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr] <= push_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-bus target: word RAM, MMIO cycle counter and GPIO, and an
// optional debug TX FIFO built only when DMEM_TXFIFO_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2     = 10,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
  parameter int          TXF_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_w,
  output logic [31:0] rdata,
  output logic [15:0] gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  logic [31:0]           mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic [7:0]            ofs;
  logic                  is_mmio, mmio_wr, mmio_rd;
  logic [63:0]           cycle;
  logic [31:0]           hi_snap;
  logic [31:0]           tx_status;
  logic                  unused_ok;

  assign idx       = addr[DEPTH_LOG2+1:2];
  assign ofs       = addr[7:0];
  assign is_mmio   = (addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_wr   = mem_w && is_mmio;
  assign mmio_rd   = !mem_w && is_mmio;
  assign unused_ok = ^{addr, tx_ready};

  // RAM is deliberately left unreset; async read returns pre-edge data on RAW
  always_ff @(posedge clk)
    if (mem_w && !is_mmio) mem[idx] <= wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle    <= '0;
      hi_snap  <= '0;
      gpio_out <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (mmio_rd && ofs == OFS_CYCLE_LO) hi_snap  <= cycle[63:32];
      if (mmio_wr && ofs == OFS_GPIO)     gpio_out <= wdata[GPIO_W-1:0];
    end
  end

`ifdef DMEM_TXFIFO_EN
  logic                    push, pop, full, empty, ovf;
  logic [TXF_DEPTH_LOG2:0] count;

  assign push     = mmio_wr && ofs == OFS_TX_DATA;
  assign pop      = !empty && tx_ready;
  assign tx_valid = !empty;

  dmem_tx_fifo #(.TXF_DEPTH_LOG2(TXF_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push(push), .push_data(wdata[7:0]), .pop(pop),
    .full(full), .empty(empty), .count(count), .head(tx_data)
  );

  // A push that meets a same-edge pop is not an overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   ovf <= 1'b0;
    else if (mmio_wr && ofs == OFS_TX_STATUS)   ovf <= 1'b0;
    else if (push && full && !pop)              ovf <= 1'b1;
  end

  always_comb begin
    tx_status                                   = '0;
    tx_status[ST_FULL]                          = full;
    tx_status[ST_EMPTY]                         = empty;
    tx_status[ST_OVF]                           = ovf;
    tx_status[ST_CNT_LSB +: TXF_DEPTH_LOG2 + 1] = count;
  end
`else
  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;

  always_comb begin
    tx_status           = '0;
    tx_status[ST_EMPTY] = 1'b1;
  end
`endif

  always_comb begin
    rdata = '0;
    if (is_mmio) begin
      case (ofs)
        OFS_CYCLE_LO:  rdata = cycle[31:0];
        OFS_CYCLE_HI:  rdata = hi_snap;
        OFS_GPIO:      rdata = {{(32-GPIO_W){1'b0}}, gpio_out};
        OFS_TX_STATUS: rdata = tx_status;
        default:       rdata = '0;
      endcase
    end else begin
      rdata = mem[idx];
    end
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32i pipelined core: the target end of the core's MEM-stage data bus (address, store data, write enable, load data). It holds a word-addressed RAM, a small memory-mapped I/O window with a 64-bit cycle counter and a GPIO register, and, optionally, a byte-wide debug TX FIFO drained by a valid/ready handshake. Load data is combinational, because the core samples it in the same cycle it drives the address.

## Interface
- DEPTH_LOG2, 10, RAM depth as log2(words); RAM is 2^DEPTH_LOG2 x 32.
- MMIO_BASE, 32'hFFFF_0000, MMIO window base; bits [31:16] select the window.
- TXF_DEPTH_LOG2, 3, TX FIFO depth as log2(entries).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  32  byte address from the core's EXE_MEM ALU result.
- wdata  in  32  store data.
- mem_w  in  1  store strobe, sampled at the rising edge.
- rdata  out  32  load data, combinational from addr.
- gpio_out  out  16  GPIO register.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  8  TX FIFO head byte; 0 when empty.
- tx_ready  in  1  downstream accepts the head byte.

## Operation
- Word accesses only. addr[1:0] is ignored, and wdata is always written whole.
- Decode:
  - MMIO when addr[31:16] == MMIO_BASE[31:16].
  - Otherwise RAM, indexed by addr[DEPTH_LOG2+1:2]. Higher address bits alias.
- RAM:
  - Write on the edge when mem_w=1.
  - Read is asynchronous. A read and write to the same word in the same cycle returns the old data.
  - RAM is not reset.
- MMIO offsets (addr[7:0]):
  - 0x00 CYCLE_LO (RO): cycle[31:0]. A read of this offset latches cycle[63:32] into hi_snap at the next edge.
  - 0x04 CYCLE_HI (RO): returns hi_snap.
  - 0x08 GPIO (RW): bits [15:0]; upper read bits are 0.
  - 0x0C TX_DATA (WO): a write pushes wdata[7:0]. Reads return 0.
  - 0x10 TX_STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bits[7:4] count. Any write clears overflow.
  - All other offsets read 0; writes to them are ignored.
- "Read" means addr decodes to that offset with mem_w=0. No read strobe exists.
- Cycle counter:
  - 64-bit, +1 every cycle out of reset.
  - Wraps from 2^64-1 to 0.
- TX FIFO:
  - Circular buffer with a count of TXF_DEPTH_LOG2+1 bits.
  - Pop on the edge when tx_valid && tx_ready.
  - Push when full: byte dropped, overflow set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push while empty: no bypass; tx_valid rises the cycle after the write edge.
  - Pointers wrap modulo depth.

## Timing
- Load latency is 0 cycles: rdata settles combinationally from addr within the same cycle.
- Store and MMIO side effects become visible from the cycle after the edge.
- Reset values:
  - gpio_out=0, cycle=0, hi_snap=0.
  - FIFO empty: tx_valid=0, tx_data=0, overflow=0.
  - rdata follows addr; RAM contents are undefined after reset.
- Reset asserted mid-transfer clears the FIFO immediately; pending bytes are lost and tx_valid drops asynchronously.
- tx_data is stable while tx_valid=1 and tx_ready=0.

## Configuration
- DMEM_TXFIFO_EN:
  - Defined: TX FIFO, the TX_DATA and TX_STATUS registers, and the handshake are as above.
  - Undefined:
    - No FIFO storage is built.
    - Writes to 0x0C are ignored, TX_STATUS reads 0x2 (empty).
    - tx_valid and tx_data are tied to 0; tx_ready is ignored.

## Structure
- Package dmem_pkg:
  - MMIO offset constants (OFS_CYCLE_LO, OFS_CYCLE_HI, OFS_GPIO, OFS_TX_DATA, OFS_TX_STATUS).
  - TX_STATUS bit positions.
  - GPIO width localparam.
- Sub-module dmem_tx_fifo, parameterised by TXF_DEPTH_LOG2.
  - Ports: push/push_data, pop, full, empty, count, head.
  - Instantiated only under DMEM_TXFIFO_EN.
- Top level holds the decode, the RAM array, the counter and the MMIO registers.

## Test plan
- RAM store/load: write 0xDEADBEEF at 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF. Read at 0x0000_1010 (alias, DEPTH_LOG2=10) -> 0xDEADBEEF.
- Same-cycle read/write: while storing 0x1 over 0x5 at the same address -> rdata=0x5 that cycle, 0x1 the next.
- GPIO: write 0xFFFF_A5A5 to MMIO_BASE+0x08 -> gpio_out=0xA5A5, readback 0x0000_A5A5. Assert rst -> gpio_out=0 immediately.
- Cycle counter: 20 cycles after reset release, read CYCLE_LO -> value within 1 of 20; following CYCLE_HI read -> 0. Force cycle to 0xFFFF_FFFF_FFFF_FFFF -> wraps to 0.
- FIFO fill with tx_ready=0: push 9 bytes 0x41..0x49 -> STATUS = count 8, full=1, overflow=1. Raise tx_ready -> bytes 0x41..0x48 appear in order, one per cycle, then tx_valid=0. Write STATUS -> overflow cleared.
- Full with push+pop same edge -> count stays 8, no overflow. Reset mid-drain -> tx_valid=0 and count=0. Build without DMEM_TXFIFO_EN -> STATUS reads 0x2, tx_valid stays 0.
